// File: rtl/sr_latch_driver.sv
// Drives Sbar/Rbar of an external NAND SR latch with guarded, fixed-width
// pulses and confirms the latch state through synchronized Q/Qbar feedback.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic Sbar,
    output logic Rbar,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic done,
    output logic err,
    output logic state_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        PULSE = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             req_set_r;
    logic             req_set_n;
    logic             done_n;
    logic             err_n;
    logic             state_q_n;
    logic             ready_n;
    logic             sbar_n;
    logic             rbar_n;

    logic q_m;
    logic q_s;
    logic qbar_m;
    logic qbar_s;

    logic accept;
    logic last;
    logic match;

    // Feedback is asynchronous to clk; two flops per line before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_m    <= 1'b0;
            q_s    <= 1'b0;
            qbar_m <= 1'b0;
            qbar_s <= 1'b0;
        end else begin
            q_m    <= q_fb;
            q_s    <= q_m;
            qbar_m <= qbar_fb;
            qbar_s <= qbar_m;
        end
    end

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign last   = (cnt == ONE);
    assign match  = (q_s == req_set_r) && (qbar_s == ~req_set_r);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req_set_n = req_set_r;
        done_n    = 1'b0;
        err_n     = 1'b0;
        state_q_n = state_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    req_set_n = req_set;
                    cnt_n     = GAP_LD;
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (last) begin
                    cnt_n   = PULSE_LD;
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            PULSE: begin
                if (last) begin
                    cnt_n   = TO_LD;
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            CHECK: begin
                // A match on the final count still wins over the timeout.
                if (match) begin
                    done_n    = 1'b1;
                    state_q_n = req_set_r;
                    state_n   = IDLE;
                end else if (last) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line drive is decoded from the next state so every output is a flop.
    always_comb begin
        ready_n = (state_n == IDLE);
        sbar_n  = ~((state_n == PULSE) && req_set_n);
        rbar_n  = ~((state_n == PULSE) && !req_set_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_set_r <= 1'b0;
            req_ready <= 1'b0;
            Sbar      <= 1'b1;
            Rbar      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            state_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_set_r <= req_set_n;
            req_ready <= ready_n;
            Sbar      <= sbar_n;
            Rbar      <= rbar_n;
            done      <= done_n;
            err       <= err_n;
            state_q   <= state_q_n;
        end
    end

    a_never_both_low: assert property (
        @(posedge clk) disable iff (reset) (Sbar || Rbar)
    );

    a_done_err_excl: assert property (
        @(posedge clk) disable iff (reset) !(done && err)
    );

endmodule
